// File: rtl/viterbi_codec_k3.sv
// viterbi_codec_k3: rate-1/2 K=3 (7,5) convolutional encoder plus 4-state hard-decision register-exchange Viterbi decoder.
// Optional VITERBI_MIN_PM_EN adds dec_min_pm, the minimum normalised path metric.
module viterbi_codec_k3 #(
  parameter int TB_DEPTH = 16,
  parameter int PM_W     = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enc_enable_i,
  input  logic            enc_d_in,
  output logic            enc_valid_o,
  output logic [1:0]      enc_d_out,
  input  logic            dec_enable,
  input  logic [1:0]      dec_d_in,
  output logic            dec_d_out,
`ifdef VITERBI_MIN_PM_EN
  output logic [PM_W-1:0] dec_min_pm,
`endif
  output logic            dec_valid_o
);
  localparam int CW = $clog2(TB_DEPTH + 1);
  localparam logic [CW-1:0] CMAX = CW'(TB_DEPTH);

  function automatic logic [1:0] bm(input logic [1:0] r, input logic [1:0] e);
    return {1'b0, r[1] ^ e[1]} + {1'b0, r[0] ^ e[0]};
  endfunction

  // lowest index wins on equal metrics
  function automatic logic [1:0] argmin(input logic [PM_W-1:0] p0, p1, p2, p3);
    logic [1:0] lo, hi;
    logic [PM_W-1:0] vlo, vhi;
    lo  = p1 < p0 ? 2'd1 : 2'd0;
    vlo = p1 < p0 ? p1 : p0;
    hi  = p3 < p2 ? 2'd3 : 2'd2;
    vhi = p3 < p2 ? p3 : p2;
    return vhi < vlo ? hi : lo;
  endfunction

  logic [1:0]          enc_s_q;
  logic [PM_W-1:0]     pm_q [4];
  logic [PM_W-1:0]     pm_raw [4];
  logic [PM_W-1:0]     pm_d [4];
  logic [TB_DEPTH-1:0] surv_q [4];
  logic [TB_DEPTH-1:0] surv_d [4];
  logic [CW-1:0]       cnt_q;
  logic [1:0]          best;
  logic                nrm;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      enc_s_q     <= '0;
      enc_d_out   <= '0;
      enc_valid_o <= 1'b0;
    end else begin
      enc_valid_o <= enc_enable_i;
      if (enc_enable_i) begin
        enc_d_out <= {enc_d_in ^ enc_s_q[1] ^ enc_s_q[0], enc_d_in ^ enc_s_q[0]};
        enc_s_q   <= {enc_d_in, enc_s_q[1]};
      end
    end

  // state i = {d,a}; predecessors {a,0} and {a,1}
  for (genvar i = 0; i < 4; i++) begin : g_acs
    localparam logic [1:0] S = 2'(i);
    logic [PM_W-1:0] m0, m1;
    logic            w;
    assign m0        = pm_q[{S[0], 1'b0}] + PM_W'(bm(dec_d_in, {S[1] ^ S[0], S[1]}));
    assign m1        = pm_q[{S[0], 1'b1}] + PM_W'(bm(dec_d_in, {~(S[1] ^ S[0]), ~S[1]}));
    assign w         = m1 < m0;
    assign pm_raw[i] = w ? m1 : m0;
    assign pm_d[i]   = nrm ? {1'b0, pm_raw[i][PM_W-2:0]} : pm_raw[i];
    assign surv_d[i] = {surv_q[{S[0], w}][TB_DEPTH-2:0], S[1]};
  end

  assign nrm  = pm_raw[0][PM_W-1] & pm_raw[1][PM_W-1] & pm_raw[2][PM_W-1] & pm_raw[3][PM_W-1];
  assign best = argmin(pm_q[0], pm_q[1], pm_q[2], pm_q[3]);

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pm_q        <= '{'0, PM_W'(8), PM_W'(8), PM_W'(8)};
      surv_q      <= '{default: '0};
      cnt_q       <= '0;
      dec_d_out   <= 1'b0;
      dec_valid_o <= 1'b0;
    end else if (dec_enable) begin
      pm_q        <= pm_d;
      surv_q      <= surv_d;
      cnt_q       <= cnt_q + CW'(cnt_q != CMAX);
      dec_d_out   <= surv_q[best][TB_DEPTH-1];
      dec_valid_o <= cnt_q == CMAX;
    end

`ifdef VITERBI_MIN_PM_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) dec_min_pm <= '0;
    else if (dec_enable) dec_min_pm <= pm_d[argmin(pm_d[0], pm_d[1], pm_d[2], pm_d[3])];
`endif
endmodule

// File: tb/tb_viterbi_codec_k3.sv
// tb_viterbi_codec_k3: encoder -> one-cycle link (optional g0 error injection) -> decoder, with a bit scoreboard.
module tb_viterbi_codec_k3;
  localparam int TBD = 16;
  localparam int PMW = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enc_enable_i = 1'b0;
  logic       enc_d_in = 1'b0;
  logic       dec_enable = 1'b0;
  logic [1:0] dec_d_in = 2'b00;
  logic       enc_valid_o;
  logic [1:0] enc_d_out;
  logic       dec_d_out;
  logic       dec_valid_o;
`ifdef VITERBI_MIN_PM_EN
  logic [PMW-1:0] dec_min_pm;
  bit             chk_min = 0;
  bit             min_done = 0;
`endif

  viterbi_codec_k3 #(.TB_DEPTH(TBD), .PM_W(PMW)) dut (
    .clk(clk),
    .rst(rst),
    .enc_enable_i(enc_enable_i),
    .enc_d_in(enc_d_in),
    .enc_valid_o(enc_valid_o),
    .enc_d_out(enc_d_out),
    .dec_enable(dec_enable),
    .dec_d_in(dec_d_in),
    .dec_d_out(dec_d_out),
`ifdef VITERBI_MIN_PM_EN
    .dec_min_pm(dec_min_pm),
`endif
    .dec_valid_o(dec_valid_o)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail = 0;
  logic       sb_q[$];
  logic [1:0] ms;
  int         dcnt;
  int         nsym;
  bit         inj = 0;
  bit         zchk = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_state();
    sb_q.delete();
    ms = 2'b00;
    dcnt = 0;
    nsym = 0;
    enc_enable_i = 1'b0;
    enc_d_in = 1'b0;
    dec_enable = 1'b0;
    dec_d_in = 2'b00;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_enc_valid"}, enc_valid_o, 0);
    check({tag, "_enc_sym"}, enc_d_out, 0);
    check({tag, "_dec_bit"}, dec_d_out, 0);
    check({tag, "_dec_valid"}, dec_valid_o, 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_cleared(tag);
    clr_state();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // one clock: drive encoder, check outputs of that edge, then forward the symbol to the decoder
  task automatic step(input logic en, input logic d);
    logic       was;
    logic [1:0] exp;
    logic       flip;
    exp = 2'b00;
    enc_enable_i = en;
    enc_d_in = d;
    was = dec_enable;
    if (en) begin
      exp = {d ^ ms[1] ^ ms[0], d ^ ms[0]};
      ms = {d, ms[1]};
      sb_q.push_back(d);
    end
    @(posedge clk);
    #1;
    check("enc_valid", enc_valid_o, en);
    if (en) check("enc_sym", enc_d_out, exp);
    if (zchk) check("zero_out", dec_d_out, 0);
    if (was) begin
      dcnt++;
      check("dec_valid", dec_valid_o, dcnt > TBD);
      if (dec_valid_o) begin
        check("sb_nonempty", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) check("dec_bit", dec_d_out, sb_q.pop_front());
      end
`ifdef VITERBI_MIN_PM_EN
      if (chk_min) begin
        check("min_pm_pos", dec_min_pm != 0, 1);
        chk_min = 0;
      end
`endif
    end
    flip = inj && enc_valid_o && (nsym % 8 == 3);
`ifdef VITERBI_MIN_PM_EN
    if (flip && !min_done) begin
      chk_min = 1;
      min_done = 1;
    end
`endif
    dec_enable = enc_valid_o;
    dec_d_in = enc_d_out ^ {flip, 1'b0};
    if (enc_valid_o) nsym++;
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (3) begin
      enc_enable_i = 1'($urandom_range(0, 1));
      enc_d_in = 1'($urandom_range(0, 1));
      dec_enable = 1'($urandom_range(0, 1));
      dec_d_in = 2'($urandom_range(0, 3));
      @(negedge clk);
      check_cleared("rst_hold");
    end
    clr_state();
    rst = 1'b1;

    step(1'b1, 1'b1);
    check("imp0", enc_d_out, 2'b11);
    step(1'b1, 1'b0);
    check("imp1", enc_d_out, 2'b10);
    step(1'b1, 1'b0);
    check("imp2", enc_d_out, 2'b11);
    step(1'b1, 1'b0);
    check("imp3", enc_d_out, 2'b00);
    step(1'b0, 1'b1);
    check("enc_hold", enc_d_out, 2'b00);

    do_reset("zero_rst");
    zchk = 1;
    repeat (40) step(1'b1, 1'b0);
    zchk = 0;

    do_reset("clean_rst");
    repeat (256) step(1'b1, 1'($urandom_range(0, 1)));

    do_reset("err_rst");
    inj = 1;
    repeat (256) step(1'b1, 1'($urandom_range(0, 1)));
    inj = 0;

    do_reset("pre_mid");
    repeat (60) step(1'b1, 1'($urandom_range(0, 1)));
    do_reset("mid_rst");
    repeat (80) step(1'b1, 1'($urandom_range(0, 1)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
